cond_adder_pipe: RTL and testbench

- Parametrised, pipelined conditional adder.
- Accepts LANES independent WIDTH-bit operand pairs per transaction and performs ADD, SUB, ADC or SBB, gated by a selectable condition flag.
- Returns the result with its destination register address and write-enable to the execution-environment write-back path.
- Holds a per-lane carry register so multi-word ADC/SBB sequences chain across transactions.

---
 rtl/cond_adder_pkg.sv | 27 ++
 rtl/cond_adder_lane.sv | 42 ++++
 rtl/cond_adder_pipe.sv | 116 +++++++++++
 tb/tb_cond_adder_pipe.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cond_adder_pkg.sv
// cond_adder_pkg: shared mode encoding, condition selector constant and exec evaluation for cond_adder_pipe.
package cond_adder_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_ADC = 2'd2,
        MODE_SBB = 2'd3
    } mode_e;

    // Widest selector / flag vector the exec helper accepts; callers zero-extend.
    localparam int SEL_MAX  = 8;
    localparam int FLAG_MAX = 256;

    // Always-execute selector for the default 8-flag configuration (MSB of a 4-bit selector).
    localparam logic [3:0] COND_ALWAYS = 4'b1000;

    function automatic logic cond_exec(input logic [SEL_MAX-1:0] sel, input logic [FLAG_MAX-1:0] fl,
                                       input int sel_w, input int nflags);
        logic [SEL_MAX-1:0] idx;
        idx = sel;
        for (int i = 0; i < SEL_MAX; i++)
            if (i >= sel_w - 1) idx[i] = 1'b0;
        return sel[sel_w-1] || ((int'(idx) < nflags) && fl[idx]);
    endfunction

endpackage

// File: rtl/cond_adder_lane.sv
// cond_adder_lane: combinational single-lane add/sub with carry-in, carry/borrow out and signed overflow.
// Optional COND_ADDER_SATURATE_EN turns ADC/SBB into saturating signed ADD/SUB.
module cond_adder_lane
    import cond_adder_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  mode_e            mode,
    input  logic             cr,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   full;

    always_comb begin
        sub   = mode[0];
        bx    = sub ? ~b : b;
`ifdef COND_ADDER_SATURATE_EN
        cin   = sub;
`else
        // cr holds a borrow for SBB, so it is inverted to form the +~cr term.
        cin   = mode[1] ? (sub ? ~cr : cr) : sub;
`endif
        full  = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
        carry = sub ? ~full[WIDTH] : full[WIDTH];
        ovf   = (a[WIDTH-1] == bx[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
`ifdef COND_ADDER_SATURATE_EN
        sum   = (mode[1] && ovf) ? (a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                                 : full[WIDTH-1:0];
`else
        sum   = full[WIDTH-1:0];
`endif
    end

endmodule

// File: rtl/cond_adder_pipe.sv
// cond_adder_pipe: pipelined multi-lane conditional ADD/SUB/ADC/SBB with per-lane carry chaining.
// Define COND_ADDER_SATURATE_EN to make modes 2/3 saturating signed ADD/SUB.
module cond_adder_pipe
    import cond_adder_pkg::*;
#(
    parameter  int WIDTH  = 32,
    parameter  int LANES  = 1,
    parameter  int STAGES = 2,
    parameter  int ADDR_W = 5,
    parameter  int NFLAGS = 8,
    localparam int SEL_W  = $clog2(NFLAGS) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] op1,
    input  logic [LANES*WIDTH-1:0] op2,
    input  logic [1:0]             mode,
    input  logic [ADDR_W-1:0]      dest,
    input  logic [SEL_W-1:0]       cond_sel,
    input  logic [NFLAGS-1:0]      flags,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] result,
    output logic [ADDR_W-1:0]      dest_out,
    output logic                   wr_en,
    output logic [LANES-1:0]       carry_out,
    output logic [LANES-1:0]       ovf_out
);

    typedef struct packed {
        logic                   valid;
        logic [LANES*WIDTH-1:0] result;
        logic [ADDR_W-1:0]      dest;
        logic                   wr_en;
        logic [LANES-1:0]       carry;
        logic [LANES-1:0]       ovf;
    } stage_t;

    stage_t [STAGES-1:0]    stg;
    stage_t [STAGES-1:0]    src;
    stage_t                 nxt;
    logic   [STAGES-1:0]    en;
    logic [LANES*WIDTH-1:0] sum;
    logic [LANES-1:0]       cy;
    logic [LANES-1:0]       ov;
    logic [LANES-1:0]       cr;
    logic                   exec;
    logic                   accept;
    logic                   cr_we;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        cond_adder_lane #(.WIDTH(WIDTH)) u_lane (
            .a    (op1[i*WIDTH +: WIDTH]),
            .b    (op2[i*WIDTH +: WIDTH]),
            .mode (mode_e'(mode)),
            .cr   (cr[i]),
            .sum  (sum[i*WIDTH +: WIDTH]),
            .carry(cy[i]),
            .ovf  (ov[i])
        );
    end

    assign exec   = cond_exec(SEL_MAX'(cond_sel), FLAG_MAX'(flags), SEL_W, NFLAGS);
    assign accept = in_valid && in_ready;
`ifdef COND_ADDER_SATURATE_EN
    assign cr_we  = accept && exec && !mode[1];
`else
    assign cr_we  = accept && exec;
`endif

    // A stage may load whenever it is empty or its successor is moving, so bubbles collapse.
    always_comb begin
        logic go;
        go = out_ready;
        en = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            go    = !stg[k].valid || go;
            en[k] = go;
        end
    end

    always_comb begin
        nxt.valid  = in_valid;
        nxt.result = exec ? sum : '0;
        nxt.dest   = dest;
        nxt.wr_en  = exec;
        nxt.carry  = exec ? cy : '0;
        nxt.ovf    = exec ? ov : '0;
        src        = '0;
        src[0]     = nxt;
        for (int k = 1; k < STAGES; k++)
            src[k] = stg[k-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg <= '0;
            cr  <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++)
                if (en[k]) stg[k] <= src[k];
            if (cr_we) cr <= cy;
        end
    end

    assign in_ready  = en[0];
    assign out_valid = stg[STAGES-1].valid;
    assign result    = stg[STAGES-1].result;
    assign dest_out  = stg[STAGES-1].dest;
    assign wr_en     = stg[STAGES-1].wr_en;
    assign carry_out = stg[STAGES-1].carry;
    assign ovf_out   = stg[STAGES-1].ovf;

endmodule

// File: tb/tb_cond_adder_pipe.sv
// tb_cond_adder_pipe: directed self-checking bench for cond_adder_pipe in its default configuration.
module tb_cond_adder_pipe;
    import cond_adder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [1:0]  mode = '0;
    logic [4:0]  dest = '0;
    logic [3:0]  cond_sel = '0;
    logic [7:0]  flags = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic [4:0]  dest_out;
    logic        wr_en;
    logic [0:0]  carry_out;
    logic [0:0]  ovf_out;

    int errors = 0;
    int checks = 0;

    cond_adder_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .mode(mode), .dest(dest), .cond_sel(cond_sel), .flags(flags),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .dest_out(dest_out),
        .wr_en(wr_en), .carry_out(carry_out), .ovf_out(ovf_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic [3:0] s, input logic [7:0] f, output bit ok);
        bit acc;
        mode = m; op1 = a; op2 = b; dest = d; cond_sel = s; flags = f; in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            ok = acc;
        end
        in_valid = 1'b0;
    endtask

    task automatic txn(input string tag, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d, input logic [3:0] s, input logic [7:0] f,
                       input logic [31:0] er, input logic ew, input logic ec, input logic eo);
        bit ok;
        int lat;
        send(m, a, b, d, s, f, ok);
        chk({tag, " accepted"}, 64'(ok), 64'd1);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 20);
        chk({tag, " latency"}, 64'(lat), 64'd1);
        chk({tag, " result"}, 64'(result), 64'(er));
        chk({tag, " wr_en"}, 64'(wr_en), 64'(ew));
        chk({tag, " carry"}, 64'(carry_out), 64'(ec));
        chk({tag, " ovf"}, 64'(ovf_out), 64'(eo));
        chk({tag, " dest"}, 64'(dest_out), 64'(d));
    endtask

    initial begin
        bit ok;
        int n;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset wr_en", 64'(wr_en), 64'd0);
        chk("reset result", 64'(result), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd1);

        txn("add",      2'd0, 32'd5,          32'd7, 5'd3,  COND_ALWAYS, 8'h00, 32'd12,         1, 0, 0);
        txn("add wrap", 2'd0, 32'hFFFF_FFFF,  32'd1, 5'd4,  COND_ALWAYS, 8'h00, 32'd0,          1, 1, 0);
        txn("adc",      2'd2, 32'd0,          32'd0, 5'd5,  COND_ALWAYS, 8'h00, 32'd1,          1, 0, 0);
        txn("sub",      2'd1, 32'd3,          32'd5, 5'd6,  COND_ALWAYS, 8'h00, 32'hFFFF_FFFE,  1, 1, 0);
        txn("sbb",      2'd3, 32'd10,         32'd3, 5'd7,  COND_ALWAYS, 8'h00, 32'd6,          1, 0, 0);
        txn("sub ovf",  2'd1, 32'h8000_0000,  32'd1, 5'd8,  COND_ALWAYS, 8'h00, 32'h7FFF_FFFF,  1, 0, 1);
        txn("add ovf",  2'd0, 32'h7FFF_FFFF,  32'd1, 5'd9,  COND_ALWAYS, 8'h00, 32'h8000_0000,  1, 0, 1);
        txn("set cr",   2'd0, 32'hFFFF_FFFF,  32'd1, 5'd10, COND_ALWAYS, 8'h00, 32'd0,          1, 1, 0);
        txn("skip",     2'd1, 32'd0,          32'd1, 5'd11, 4'd2,        8'h00, 32'd0,          0, 0, 0);
        txn("adc kept", 2'd2, 32'd0,          32'd0, 5'd12, COND_ALWAYS, 8'h00, 32'd1,          1, 0, 0);
        txn("cond hit", 2'd0, 32'd2,          32'd3, 5'd13, 4'd2,        8'h04, 32'd5,          1, 0, 0);

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    send(2'd0, 32'(i + 1), 32'd100, 5'(i), COND_ALWAYS, 8'h00, ok);
                    chk($sformatf("stream accept%0d", i), 64'(ok), 64'd1);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("stall in_ready", 64'(in_ready), 64'd0);
                chk("stall out_valid", 64'(out_valid), 64'd1);
                for (int c = 4; c <= 10; c++) begin
                    @(posedge clk);
                    #1;
                    chk($sformatf("stall hold%0d", c), 64'(result), 64'd101);
                    chk($sformatf("stall dest%0d", c), 64'(dest_out), 64'd0);
                end
                @(posedge clk);
                #3 out_ready = 1'b1;
                n = 0;
                for (int t = 0; t < 40 && n < 6; t++) begin
                    if (out_valid) begin
                        chk($sformatf("stream%0d result", n), 64'(result), 64'(101 + n));
                        chk($sformatf("stream%0d dest", n), 64'(dest_out), 64'(n));
                        n++;
                    end
                    @(posedge clk);
                    #1;
                end
                chk("stream count", 64'(n), 64'd6);
                chk("stream drained", 64'(out_valid), 64'd0);
            end
        join

        out_ready = 1'b0;
        send(2'd0, 32'hFFFF_FFFF, 32'd1, 5'd20, COND_ALWAYS, 8'h00, ok);
        chk("flight0 accept", 64'(ok), 64'd1);
        send(2'd0, 32'hFFFF_FFFF, 32'd1, 5'd21, COND_ALWAYS, 8'h00, ok);
        chk("flight1 accept", 64'(ok), 64'd1);
        chk("flight out_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst result", 64'(result), 64'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        txn("adc post rst", 2'd2, 32'd1, 32'd1, 5'd22, COND_ALWAYS, 8'h00, 32'd2, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
